gigabit_ingress_reader: RTL and testbench
=========================================

GIGABIT_INGRESS_READER -- requirements
Module: GigabitIngressReader

Interface
REQ-001 Parameter DEPTH, default 4096, URAM ingress buffer depth in 72-bit words.
REQ-002 Parameter ADDR_BITS, default $clog2(DEPTH), buffer address width.
REQ-003 Parameter RD_LATENCY, default 2, cycles from rd_en to valid rd_data.
REQ-004 Port aclk, input, 1, single clock for all logic.
REQ-005 Port areset_n, input, 1, asynchronous active-low reset.
REQ-006 Port wr_ptr_committed, input, ADDR_BITS+1, writer's committed pointer (wrap bit in MSB).
REQ-007 Port rd_ptr, output, ADDR_BITS+1, words released back to the writer.
REQ-008 Port rd_en, output, 1, URAM read strobe.
REQ-009 Port rd_addr, output, ADDR_BITS, URAM read address.
REQ-010 Port rd_data, input, 72, URAM read data; bits 71:64 ignored.
REQ-011 Port m_tvalid / m_tready, output / input, 1 each, AXI-stream handshake.
REQ-012 Port m_tdata, output, 64, frame data; bits 31:0 carry the earlier bytes.
REQ-013 Port m_tkeep, output, 8, valid-byte mask.
REQ-014 Port m_tlast, output, 1, last beat of frame.
REQ-015 Port m_tdest, output, 12, frame VLAN ID, constant across the frame.

Function
REQ-016 Buffer format: header word at frame start, VLAN in 27:16 and byte length in 10:0; then ceil(len/8) data words.
REQ-017 FSM states: IDLE, HDR_WAIT, DATA, RELEASE.
REQ-018 IDLE: when rd_ptr != wr_ptr_committed, pulse rd_en with rd_addr = rd_ptr[ADDR_BITS-1:0]; go to HDR_WAIT.
REQ-019 HDR_WAIT: after exactly RD_LATENCY cycles, latch VLAN and length, and compute word count nwords = (len+7)>>3.
REQ-020 Zero length: nwords=0 goes directly to RELEASE with no output beats.
REQ-021 DATA: issue rd_en for words rd_ptr+1 .. rd_ptr+nwords, addresses modulo DEPTH, one per cycle at most.
REQ-022 Reads land in an internal output FIFO of 4 entries.
REQ-023 A read is issued only when (FIFO occupancy + reads in flight) < 4, so the FIFO never overflows.
REQ-024 Output beats come from the output FIFO.
REQ-025 m_tdata, m_tkeep, m_tlast and m_tdest hold stable while m_tvalid && !m_tready.
REQ-026 m_tkeep = 0xFF except on the last beat.
REQ-027 Last beat: m_tkeep = 0xFF if len[2:0]==0, else the (len[2:0]) LSBs set.
REQ-028 m_tlast is asserted only on beat nwords.
REQ-029 RELEASE entry: DATA moves to RELEASE on the cycle the last beat handshakes; nwords=0 enters RELEASE directly from HDR_WAIT.
REQ-030 RELEASE: rd_ptr <= rd_ptr + 1 + nwords, (ADDR_BITS+1)-bit wrapping arithmetic; next state IDLE.
REQ-031 rd_ptr changes only in RELEASE; partially read frames never free space.
REQ-032 The next header read may issue the cycle after RELEASE. Back-to-back frames have no gap on m_tvalid beyond header latency (RD_LATENCY+2 cycles).
REQ-033 The header read is issued only when the buffer is non-empty; a data read never goes past the current frame.
REQ-034 Length field above 2047 cannot occur (11-bit field); no range check.

Reset
REQ-035 On areset_n low, asynchronously clear to 0: rd_ptr, rd_en, rd_addr, m_tvalid, m_tlast, m_tkeep, m_tdata, m_tdest.
REQ-036 On areset_n low, also clear FIFO occupancy and in-flight counters; FSM returns to IDLE.
REQ-037 Reset mid-frame discards the partial frame with no further beats; rd_ptr restarts at 0, matching the writer, which shares this reset.

Verification
REQ-038 Header {vlan=5,len=60} at 0, wr_ptr_committed=9 -> 8 beats, tdest=5, last tkeep=0x0F, rd_ptr 0->9 one cycle after last handshake.
REQ-039 m_tready low 10 cycles mid-frame -> no lost or duplicated beats; in-flight+occupancy never exceeds 4; rd_en stalls.
REQ-040 Header len=0 -> no m_tvalid; rd_ptr advances by 1.
REQ-041 rd_ptr=4094, len=24 -> rd_addr sequence 4094,4095,0,1; rd_ptr=4098 (13-bit) afterwards.
REQ-042 rd_ptr==wr_ptr_committed held 100 cycles -> rd_en and m_tvalid stay 0.
REQ-043 areset_n pulsed low during beat 3 of 8 -> all outputs 0 immediately; next frame starts with a header read at address 0.

Source files
------------

// File: rtl/gigabit_ingress_reader.sv
// rtl/gigabit_ingress_reader.sv - frame reader from a URAM ingress ring buffer to an AXI-stream master
//
// Walks frames that a writer has committed into the ingress buffer. Each frame
// is one header word (VLAN in 27:16, byte length in 10:0) followed by
// ceil(len/8) data words. Data words are streamed out on m_* with the VLAN on
// m_tdest. Buffer space is handed back through rd_ptr only after the whole
// frame has been consumed.
//
// Ports:
//   aclk, areset_n      clock, asynchronous active-low reset
//   wr_ptr_committed    writer's committed pointer (MSB is the wrap bit)
//   rd_ptr              words released back to the writer (MSB is the wrap bit)
//   rd_en, rd_addr      URAM read strobe and address
//   rd_data             URAM read data, valid RD_LATENCY cycles after rd_en
//   m_tvalid, m_tready  output stream handshake
//   m_tdata, m_tkeep    beat data (bits 31:0 carry the earlier bytes), byte mask
//   m_tlast, m_tdest    last beat of frame, frame VLAN ID
module gigabit_ingress_reader #(
  parameter int DEPTH      = 4096,
  parameter int ADDR_BITS  = $clog2(DEPTH),
  parameter int RD_LATENCY = 2
) (
  input  logic                 aclk,
  input  logic                 areset_n,
  input  logic [ADDR_BITS:0]   wr_ptr_committed,
  output logic [ADDR_BITS:0]   rd_ptr,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [71:0]          rd_data,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [63:0]          m_tdata,
  output logic [7:0]           m_tkeep,
  output logic                 m_tlast,
  output logic [11:0]          m_tdest
);

  typedef enum logic [1:0] {IDLE, HDR_WAIT, DATA, RELEASE} state_t;

  state_t                 state;

  // One bit per outstanding read; the top bit marks the cycle rd_data is valid.
  logic [RD_LATENCY-1:0]  rd_pipe;

  logic [10:0]            len_q;
  logic [11:0]            vlan_q;
  logic [8:0]             nwords_q;
  logic [8:0]             issued_q;
  logic [8:0]             out_beat_q;
  logic [ADDR_BITS-1:0]   next_addr_q;

  logic [63:0]            fifo_mem [4];
  logic [1:0]             wr_idx;
  logic [1:0]             rd_idx;
  logic [2:0]             fifo_cnt;
  logic [2:0]             inflight;

  logic                   land;
  logic [11:0]            len_p7;
  logic [8:0]             hdr_nwords;
  logic [3:0]             committed;
  logic                   has_credit;
  logic                   issue_first;
  logic                   issue_data;
  logic                   issue;
  logic                   push;
  logic                   load;
  logic [8:0]             beat_num;
  logic [8:0]             keep_mask;
  logic [7:0]             last_keep;
  logic                   frame_done;
  logic                   unused_bits;

  assign land        = rd_pipe[RD_LATENCY-1];
  assign len_p7      = {1'b0, rd_data[10:0]} + 12'd7;
  assign hdr_nwords  = len_p7[11:3];

  // The output register counts as a FIFO slot so total buffering stays at 4.
  assign committed   = 4'(fifo_cnt) + 4'(m_tvalid) + 4'(inflight);
  assign has_credit  = committed < 4'd4;

  // The first data read goes out on the same edge the header is latched.
  assign issue_first = (state == HDR_WAIT) && land && (hdr_nwords != 9'd0);
  assign issue_data  = (state == DATA) && (issued_q < nwords_q) && has_credit;
  assign issue       = issue_first || issue_data;

  // Only data reads can land while in DATA; the header lands in HDR_WAIT.
  assign push        = land && (state == DATA);
  assign load        = (fifo_cnt != 3'd0) && (!m_tvalid || m_tready);

  assign beat_num    = out_beat_q + 9'd1;
  assign keep_mask   = (9'd1 << len_q[2:0]) - 9'd1;
  assign last_keep   = (len_q[2:0] == 3'd0) ? 8'hFF : keep_mask[7:0];
  assign frame_done  = (state == DATA) && m_tvalid && m_tready && m_tlast;

  assign unused_bits = ^{rd_data[71:64], len_p7[2:0], keep_mask[8]};

  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_mem[wr_idx] <= rd_data[63:0];
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      m_tkeep     <= '0;
      m_tdata     <= '0;
      m_tdest     <= '0;
      rd_pipe     <= '0;
      len_q       <= '0;
      vlan_q      <= '0;
      nwords_q    <= '0;
      issued_q    <= '0;
      out_beat_q  <= '0;
      next_addr_q <= '0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      fifo_cnt    <= '0;
      inflight    <= '0;
    end else begin
      rd_en      <= 1'b0;
      rd_pipe[0] <= rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end

      if (push) begin
        wr_idx <= wr_idx + 2'd1;
      end
      fifo_cnt <= fifo_cnt + 3'(push) - 3'(load);
      inflight <= inflight + 3'(issue) - 3'(push);

      if (load) begin
        rd_idx     <= rd_idx + 2'd1;
        m_tvalid   <= 1'b1;
        m_tdata    <= fifo_mem[rd_idx];
        m_tkeep    <= (beat_num == nwords_q) ? last_keep : 8'hFF;
        m_tlast    <= (beat_num == nwords_q);
        m_tdest    <= vlan_q;
        out_beat_q <= beat_num;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rd_ptr != wr_ptr_committed) begin
            rd_en   <= 1'b1;
            rd_addr <= rd_ptr[ADDR_BITS-1:0];
            state   <= HDR_WAIT;
          end
        end

        HDR_WAIT: begin
          if (land) begin
            len_q      <= rd_data[10:0];
            vlan_q     <= rd_data[27:16];
            nwords_q   <= hdr_nwords;
            out_beat_q <= '0;
            if (hdr_nwords == 9'd0) begin
              state <= RELEASE;
            end else begin
              rd_en       <= 1'b1;
              rd_addr     <= rd_ptr[ADDR_BITS-1:0] + ADDR_BITS'(1);
              next_addr_q <= rd_ptr[ADDR_BITS-1:0] + ADDR_BITS'(2);
              issued_q    <= 9'd1;
              state       <= DATA;
            end
          end
        end

        DATA: begin
          if (issue_data) begin
            rd_en       <= 1'b1;
            rd_addr     <= next_addr_q;
            next_addr_q <= next_addr_q + ADDR_BITS'(1);
            issued_q    <= issued_q + 9'd1;
          end
          if (frame_done) begin
            state <= RELEASE;
          end
        end

        RELEASE: begin
          rd_ptr <= rd_ptr + (ADDR_BITS+1)'(nwords_q) + (ADDR_BITS+1)'(1);
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gigabit_ingress_reader.sv
// tb/tb_gigabit_ingress_reader.sv - self-checking bench for gigabit_ingress_reader
module tb_gigabit_ingress_reader;

  localparam int DEPTH = 4096;
  localparam int AB    = 12;
  localparam int LAT   = 2;

  logic          aclk;
  logic          areset_n;
  logic [AB:0]   wr_ptr_committed;
  logic [AB:0]   rd_ptr;
  logic          rd_en;
  logic [AB-1:0] rd_addr;
  logic [71:0]   rd_data;
  logic          m_tvalid;
  logic          m_tready;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic          m_tlast;
  logic [11:0]   m_tdest;

  gigabit_ingress_reader #(.DEPTH(DEPTH), .ADDR_BITS(AB), .RD_LATENCY(LAT)) dut (
    .aclk(aclk), .areset_n(areset_n), .wr_ptr_committed(wr_ptr_committed),
    .rd_ptr(rd_ptr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tdest(m_tdest)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // URAM model: registered read with LAT stages
  logic [71:0] mem [DEPTH];
  logic [71:0] mpipe [LAT];
  always @(posedge aclk) begin
    mpipe[0] <= mem[rd_addr];
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign rd_data = mpipe[LAT-1];

  typedef struct packed { logic [63:0] data; logic [7:0] keep; logic last; logic [11:0] dest; } beat_t;
  typedef struct packed { logic [AB-1:0] addr; logic hdr; } rd_t;
  typedef struct packed { logic [AB:0] ptr; int cum; logic has_beats; } rel_t;

  beat_t beat_q[$];
  rd_t   rd_q[$];
  rel_t  rel_q[$];
  int    addr_log[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int data_rd_cnt = 0;
  int hs_cnt = 0;
  int cum_beats = 0;
  int last_hs_cyc = 0;
  int beats_seen = 0;
  logic [11:0] last_dest;
  logic [7:0]  last_keep;
  logic [AB:0] wr;
  int rmode = 1;

  logic        prev_v, prev_r;
  logic [84:0] prev_bundle;
  logic [AB:0] prev_ptr;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // m_tready driver
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (rmode)
        0:       m_tready = ($urandom_range(0, 99) < 70);
        1:       m_tready = 1'b1;
        default: m_tready = 1'b0;
      endcase
    end
  end

  // compare process: checks every read, every beat and every release
  always @(negedge aclk) begin
    rd_t   r;
    beat_t b;
    rel_t  rl;
    cyc++;
    if (!areset_n) begin
      prev_v   = 1'b0;
      prev_r   = 1'b0;
      prev_ptr = '0;
    end else begin
      if (rd_en) begin
        addr_log.push_back(int'(rd_addr));
        if (rd_q.size() == 0) chk("spurious_rd_en", 64'(rd_addr), 64'hFFFF);
        else begin
          r = rd_q.pop_front();
          chk("rd_addr", 64'(rd_addr), 64'(r.addr));
          if (!r.hdr) data_rd_cnt++;
          chk("outstanding_le4", 64'((data_rd_cnt - hs_cnt) <= 4), 64'd1);
        end
      end
      if (prev_v && !prev_r) begin
        chk("hold_valid", 64'(m_tvalid), 64'd1);
        chk("hold_beat", 64'({m_tdata, m_tkeep, m_tlast, m_tdest} == prev_bundle), 64'd1);
      end
      if (m_tvalid && m_tready) begin
        if (beat_q.size() == 0) chk("spurious_beat", 64'(m_tvalid), 64'd0);
        else begin
          b = beat_q.pop_front();
          chk("tdata", m_tdata, b.data);
          chk("tkeep", 64'(m_tkeep), 64'(b.keep));
          chk("tlast", 64'(m_tlast), 64'(b.last));
          chk("tdest", 64'(m_tdest), 64'(b.dest));
        end
        hs_cnt++;
        beats_seen++;
        last_keep = m_tkeep;
        last_dest = m_tdest;
        if (m_tlast) last_hs_cyc = cyc;
      end
      if (rd_ptr != prev_ptr) begin
        if (rel_q.size() == 0) chk("spurious_release", 64'(rd_ptr), 64'(prev_ptr));
        else begin
          rl = rel_q.pop_front();
          chk("rd_ptr", 64'(rd_ptr), 64'(rl.ptr));
          chk("release_after_beats", 64'(hs_cnt), 64'(rl.cum));
          if (rl.has_beats) chk("release_timing", 64'(cyc - last_hs_cyc), 64'd2);
        end
      end
      prev_v      = m_tvalid;
      prev_r      = m_tready;
      prev_bundle = {m_tdata, m_tkeep, m_tlast, m_tdest};
      prev_ptr    = rd_ptr;
    end
  end

  task automatic write_frame(input logic [11:0] vlan, input logic [10:0] len);
    int          nw;
    int          need;
    int          guard;
    logic [AB:0] used;
    logic [95:0] rnd;
    logic [71:0] w;
    beat_t       b;
    nw    = (int'(len) + 7) / 8;
    need  = 1 + nw;
    guard = 0;
    used  = wr - rd_ptr;
    while (int'(used) + need > DEPTH) begin
      @(negedge aclk);
      used = wr - rd_ptr;
      guard++;
      if (guard > 20000) begin
        chk("space_timeout", 64'(guard), 64'd0);
        return;
      end
    end
    rnd = {$urandom, $urandom, $urandom};
    w = rnd[71:0];
    w[27:16] = vlan;
    w[10:0]  = len;
    mem[wr[AB-1:0]] = w;
    rd_q.push_back('{addr: wr[AB-1:0], hdr: 1'b1});
    for (int i = 1; i <= nw; i++) begin
      logic [AB:0] a;
      a   = wr + (AB+1)'(i);
      rnd = {$urandom, $urandom, $urandom};
      mem[a[AB-1:0]] = rnd[71:0];
      rd_q.push_back('{addr: a[AB-1:0], hdr: 1'b0});
      b.data = rnd[63:0];
      b.last = (i == nw);
      b.dest = vlan;
      if (i == nw && (len % 8) != 0) b.keep = 8'((1 << (len % 8)) - 1);
      else b.keep = 8'hFF;
      beat_q.push_back(b);
    end
    cum_beats += nw;
    wr = wr + (AB+1)'(need);
    rel_q.push_back('{ptr: wr, cum: cum_beats, has_beats: (nw > 0)});
    wr_ptr_committed = wr;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (rd_q.size() != 0 || beat_q.size() != 0 || rel_q.size() != 0) begin
      @(negedge aclk);
      guard++;
      if (guard > 30000) begin
        chk("drain_timeout", 64'(rel_q.size()), 64'd0);
        return;
      end
    end
    repeat (3) @(negedge aclk);
  endtask

  initial begin
    int n;
    int guard;
    int stall_rd;
    int idle_hits;
    logic [10:0] len;
    areset_n = 1'b1;
    wr_ptr_committed = '0;
    wr = '0;
    #2 areset_n = 1'b0;
    #1;
    chk("reset_rd_ptr", 64'(rd_ptr), 64'd0);
    chk("reset_rd_en", 64'(rd_en), 64'd0);
    chk("reset_tvalid", 64'(m_tvalid), 64'd0);
    repeat (4) @(negedge aclk);
    areset_n = 1'b1;
    @(negedge aclk);

    // frame {vlan=5,len=60} at address 0
    rmode = 1;
    beats_seen = 0;
    write_frame(12'd5, 11'd60);
    wait_drain();
    chk("t038_beats", 64'(beats_seen), 64'd8);
    chk("t038_tdest", 64'(last_dest), 64'd5);
    chk("t038_last_keep", 64'(last_keep), 64'h0F);
    chk("t038_rd_ptr", 64'(rd_ptr), 64'd9);

    // zero-length frame
    beats_seen = 0;
    write_frame(12'd9, 11'd0);
    wait_drain();
    chk("t040_beats", 64'(beats_seen), 64'd0);
    chk("t040_rd_ptr", 64'(rd_ptr), 64'd10);

    // back-pressure for 10 cycles mid-frame
    beats_seen = 0;
    write_frame(12'd7, 11'd100);
    guard = 0;
    while (beats_seen < 3 && guard < 1000) begin @(negedge aclk); guard++; end
    chk("t039_reach_beat3", 64'(beats_seen >= 3), 64'd1);
    rmode = 2;
    stall_rd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (i >= 5 && rd_en) stall_rd++;
    end
    chk("t039_rd_en_stalled", 64'(stall_rd), 64'd0);
    rmode = 1;
    wait_drain();
    chk("t039_beats", 64'(beats_seen), 64'd13);
    chk("t039_rd_ptr", 64'(rd_ptr), 64'd24);

    // advance to 4094 then wrap with a 24-byte frame
    rmode = 0;
    for (int k = 0; k < 15; k++) write_frame(12'($urandom_range(0, 4095)), 11'd2040);
    write_frame(12'd77, 11'd1830);
    wait_drain();
    chk("t041_pre_ptr", 64'(rd_ptr), 64'd4094);
    addr_log.delete();
    write_frame(12'd3, 11'd24);
    wait_drain();
    chk("t041_nreads", 64'(addr_log.size()), 64'd4);
    if (addr_log.size() == 4) begin
      chk("t041_addr0", 64'(addr_log[0]), 64'd4094);
      chk("t041_addr1", 64'(addr_log[1]), 64'd4095);
      chk("t041_addr2", 64'(addr_log[2]), 64'd0);
      chk("t041_addr3", 64'(addr_log[3]), 64'd1);
    end
    chk("t041_rd_ptr", 64'(rd_ptr), 64'd4098);

    // randomized frames with random back-pressure and gaps
    for (n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) len = 11'd0;
      else if (r == 1) len = 11'($urandom_range(0, 2047));
      else len = 11'($urandom_range(1, 120));
      write_frame(12'($urandom_range(0, 4095)), len);
      repeat ($urandom_range(0, 5)) @(negedge aclk);
    end
    wait_drain();
    chk("rand_rd_ptr_caught_up", 64'(rd_ptr), 64'(wr));

    // empty buffer held for 100 cycles
    idle_hits = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (rd_en || m_tvalid) idle_hits++;
    end
    chk("t042_idle", 64'(idle_hits), 64'd0);

    // reset during beat 3 of 8
    rmode = 1;
    beats_seen = 0;
    write_frame(12'd11, 11'd64);
    guard = 0;
    while (!(beats_seen == 2 && m_tvalid) && guard < 1000) begin @(negedge aclk); guard++; end
    chk("t043_reach_beat3", 64'(guard < 1000), 64'd1);
    areset_n = 1'b0;
    wr_ptr_committed = '0;
    #1;
    chk("t043_rd_ptr", 64'(rd_ptr), 64'd0);
    chk("t043_rd_en", 64'(rd_en), 64'd0);
    chk("t043_rd_addr", 64'(rd_addr), 64'd0);
    chk("t043_tvalid", 64'(m_tvalid), 64'd0);
    chk("t043_tlast", 64'(m_tlast), 64'd0);
    chk("t043_tkeep", 64'(m_tkeep), 64'd0);
    chk("t043_tdata", m_tdata, 64'd0);
    chk("t043_tdest", 64'(m_tdest), 64'd0);
    rd_q.delete();
    beat_q.delete();
    rel_q.delete();
    wr = '0;
    cum_beats = 0;
    data_rd_cnt = 0;
    hs_cnt = 0;
    repeat (3) @(negedge aclk);
    areset_n = 1'b1;
    addr_log.delete();
    beats_seen = 0;
    @(negedge aclk);
    write_frame(12'd12, 11'd16);
    wait_drain();
    chk("t043_first_addr", 64'(addr_log.size() > 0 ? addr_log[0] : -1), 64'd0);
    chk("t043_beats", 64'(beats_seen), 64'd2);
    chk("t043_rd_ptr_after", 64'(rd_ptr), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
